// File: rtl/score_button_conditioner.sv
// score_button_conditioner
// Conditions two raw, bouncing player buttons for the scoreboard controller.
// Each channel is synchronised and debounced. A small FSM turns the debounced
// levels into single-cycle score pulses, which are issued on release. Holding
// both buttons for a long time produces a game-clear pulse instead.

module score_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       p1_button_i,
  input  logic       p2_button_i,
  output logic       p1_press_o,
  output logic       p2_press_o,
  output logic       clear_o,
  output logic       p1_level_o,
  output logic       p2_level_o,
  output logic [2:0] state_o
);

  // Counter widths and terminal counts
  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  // FSM encodings (visible on state_o)
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] P1_HELD   = 3'd1;
  localparam logic [2:0] P2_HELD   = 3'd2;
  localparam logic [2:0] BOTH_HELD = 3'd3;
  localparam logic [2:0] LOCKOUT   = 3'd4;

  // ------------------------------------------------------------------
  // Synchroniser and debounce state, indexed [0]=player 1, [1]=player 2
  // ------------------------------------------------------------------
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [DW-1:0] p1_cnt;
  logic [DW-1:0] p2_cnt;
  logic [DW-1:0] p1_cnt_nxt;
  logic [DW-1:0] p2_cnt_nxt;
  logic [1:0]    deb_nxt;

  assign raw = {p2_button_i, p1_button_i};

  // Two-flop synchroniser for both raw buttons
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Player-1 debounce: flip only after an unbroken run of mismatching cycles
  always_comb begin
    p1_cnt_nxt = p1_cnt;
    deb_nxt[0] = deb[0];
    if (sync2[0] == deb[0]) begin
      p1_cnt_nxt = {DW{1'b0}};
    end else if (p1_cnt == DEB_LAST) begin
      p1_cnt_nxt = {DW{1'b0}};
      deb_nxt[0] = sync2[0];
    end else begin
      p1_cnt_nxt = p1_cnt + DEB_ONE;
    end
  end

  // Player-2 debounce: same rule as player 1
  always_comb begin
    p2_cnt_nxt = p2_cnt;
    deb_nxt[1] = deb[1];
    if (sync2[1] == deb[1]) begin
      p2_cnt_nxt = {DW{1'b0}};
    end else if (p2_cnt == DEB_LAST) begin
      p2_cnt_nxt = {DW{1'b0}};
      deb_nxt[1] = sync2[1];
    end else begin
      p2_cnt_nxt = p2_cnt + DEB_ONE;
    end
  end

  // Debounce registers for both channels
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      deb    <= 2'b00;
      p1_cnt <= {DW{1'b0}};
      p2_cnt <= {DW{1'b0}};
    end else begin
      deb    <= deb_nxt;
      p1_cnt <= p1_cnt_nxt;
      p2_cnt <= p2_cnt_nxt;
    end
  end

  // ------------------------------------------------------------------
  // Press / combo FSM on the debounced levels
  // ------------------------------------------------------------------
  logic          d1;
  logic          d2;
  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [HW-1:0] hcnt;
  logic [HW-1:0] hcnt_nxt;
  logic          p1_fire;
  logic          p2_fire;
  logic          clear_fire;

  assign d1 = deb[0];
  assign d2 = deb[1];

  // Next-state logic; a score is only issued when a lone button is released,
  // and any two-button episode ends in LOCKOUT so its releases never score
  always_comb begin
    state_nxt  = state;
    hcnt_nxt   = {HW{1'b0}};
    p1_fire    = 1'b0;
    p2_fire    = 1'b0;
    clear_fire = 1'b0;
    case (state)
      IDLE: begin
        if (d1 && !d2) begin
          state_nxt = P1_HELD;
        end else if (!d1 && d2) begin
          state_nxt = P2_HELD;
        end else if (d1 && d2) begin
          state_nxt = BOTH_HELD;
        end else begin
          state_nxt = IDLE;
        end
      end
      P1_HELD: begin
        // The second button arriving cancels the pending press, even when
        // it coincides with the first button's release
        if (d2) begin
          state_nxt = BOTH_HELD;
        end else if (!d1) begin
          state_nxt = IDLE;
          p1_fire   = 1'b1;
        end else begin
          state_nxt = P1_HELD;
        end
      end
      P2_HELD: begin
        if (d1) begin
          state_nxt = BOTH_HELD;
        end else if (!d2) begin
          state_nxt = IDLE;
          p2_fire   = 1'b1;
        end else begin
          state_nxt = P2_HELD;
        end
      end
      BOTH_HELD: begin
        if (!(d1 && d2)) begin
          state_nxt = LOCKOUT;
        end else if (hcnt == HOLD_LAST) begin
          state_nxt  = LOCKOUT;
          clear_fire = 1'b1;
        end else begin
          state_nxt = BOTH_HELD;
          hcnt_nxt  = hcnt + HOLD_ONE;
        end
      end
      LOCKOUT: begin
        if (!d1 && !d2) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = LOCKOUT;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state and long-hold counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      hcnt  <= {HW{1'b0}};
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
    end
  end

  // ------------------------------------------------------------------
  // Registered outputs
  // ------------------------------------------------------------------
  logic p1_press;
  logic p2_press;
  logic clear_arm;
  logic clear_pulse;

  // Press pulses coincide with the FSM returning to IDLE; the clear pulse is
  // issued the cycle after the FSM commits to LOCKOUT
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p1_press    <= 1'b0;
      p2_press    <= 1'b0;
      clear_arm   <= 1'b0;
      clear_pulse <= 1'b0;
    end else begin
      p1_press    <= p1_fire;
      p2_press    <= p2_fire;
      clear_arm   <= clear_fire;
      clear_pulse <= clear_arm;
    end
  end

  assign p1_press_o = p1_press;
  assign p2_press_o = p2_press;
  assign clear_o    = clear_pulse;
  assign p1_level_o = deb[0];
  assign p2_level_o = deb[1];
  assign state_o    = state;

endmodule

// File: doc/score_button_conditioner.md
Name: score_button_conditioner

Overview:
Input-conditioning stage directly upstream of the scoreboard controller.
- Takes the two raw, asynchronous, bouncing player push-buttons.
- Emits clean single-cycle score pulses for the scoreboard controller's button inputs.
- Emits a game-clear pulse when both buttons are held together for a long period.
- A score is issued on button release, so a two-button combination never leaks a stray point.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive cycles a synchronised input must differ from its debounced state before the state flips (10 ms at 25 MHz); must be >= 2.
- LONG_CYCLES, 50000000, cycles both debounced buttons must be held before clear_o fires (2 s at 25 MHz); must be >= 2.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous active-high reset
- p1_button_i  input  1  raw player-1 button, active-high, asynchronous to clk_i
- p2_button_i  input  1  raw player-2 button, active-high, asynchronous to clk_i
- p1_press_o  output  1  one-cycle pulse: valid player-1 press completed
- p2_press_o  output  1  one-cycle pulse: valid player-2 press completed
- clear_o  output  1  one-cycle pulse: both buttons held LONG_CYCLES
- p1_level_o  output  1  debounced player-1 level (debug)
- p2_level_o  output  1  debounced player-2 level (debug)
- state_o  output  3  current FSM state encoding (debug)

Behaviour:
Reset:
- rst_i asserts asynchronously and all flops clear at once.
- All outputs are 0 and the FSM is in IDLE.
- A reset mid-press discards any pending press or clear; no pulse appears after reset deasserts.

Synchroniser:
- Per channel, two flops (s1, s2), reset 0.
- A raw change is first visible in s2 two clock edges later.

Debounce (per channel; registers deb, cnt; counter width $clog2(DEBOUNCE_CYCLES)):
- If s2 == deb: cnt <= 0.
- Else if cnt == DEBOUNCE_CYCLES-1: deb <= s2, cnt <= 0.
- Else: cnt <= cnt+1.
- Result: deb flips only after DEBOUNCE_CYCLES consecutive mismatching cycles. Any glitch shorter than that is ignored and restarts the count.
- p1_level_o / p2_level_o = deb.

FSM (encodings: IDLE=0, P1_HELD=1, P2_HELD=2, BOTH_HELD=3, LOCKOUT=4), evaluated on debounced levels d1, d2:
- IDLE:
  - d1 & !d2 -> P1_HELD
  - !d1 & d2 -> P2_HELD
  - d1 & d2 -> BOTH_HELD
- P1_HELD:
  - !d1 & !d2 -> IDLE, p1_press_o=1 next cycle
  - d2 -> BOTH_HELD (p1 press cancelled)
- P2_HELD: symmetric to P1_HELD.
- BOTH_HELD:
  - hcnt (width $clog2(LONG_CYCLES)) increments each cycle from 0.
  - hcnt == LONG_CYCLES-1 with d1 & d2 -> LOCKOUT, clear_o=1 next cycle.
  - Either released earlier -> LOCKOUT, no pulse.
  - hcnt clears on leaving the state.
- LOCKOUT:
  - Stay while d1 | d2.
  - !d1 & !d2 -> IDLE with no pulse, so releases after a combo never score.
- An undefined encoding -> IDLE.

Outputs:
- All outputs are registered and each pulse is exactly 1 cycle.
- At most one of p1_press_o, p2_press_o, clear_o is high in any cycle.

Latency:
- Raw release to press pulse = 2 (sync) + DEBOUNCE_CYCLES + 1 (FSM) = DEBOUNCE_CYCLES+3 clock edges for a clean release.
- Clear pulse appears LONG_CYCLES+1 edges after BOTH_HELD is entered.

Simultaneous debounced edges:
- d1 and d2 both rise in the same cycle from IDLE -> BOTH_HELD.
- d1 falls in the same cycle d2 rises, in P1_HELD -> BOTH_HELD (cancellation wins).

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=8 unless stated):
- Reset asserted asynchronously mid-hold of p1 -> all outputs 0 immediately; after deassert with p1 already released, no p1_press_o ever appears.
- p1 held 20 cycles, then released cleanly -> exactly one p1_press_o pulse, 7 edges after the release edge; p2_press_o and clear_o stay 0.
- p2 driven with 3-cycle high glitches separated by 1-cycle lows for 40 cycles -> p2_level_o never rises; no pulses.
- p1 pressed, p2 pressed 10 cycles later, both held 30 cycles, then both released -> clear_o exactly once, 9 edges after state_o becomes 3; no press pulses; state_o returns to 0.
- Both pressed, p2 released after 5 debounced cycles (< LONG_CYCLES) -> state 3 then 4, no clear_o; after p1 is released, state 0 and no press pulses.
- Alternating clean p1/p2 presses, 10 each -> 10 p1_press_o and 10 p2_press_o pulses, never overlapping, each 1 cycle wide.
